// File: rtl/mem_access_responder_if.sv
// EX/MEM-side request bus and MEM/WB-side response bus of the data-memory responder.
// The pipeline (master) drives the registered request; the responder (slave) answers.
interface mem_access_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        Stall;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        MemErr;
  logic [5:0]  AccessCount;

  modport master (
    output MemWrite, MemRead, Address, WriteData,
    input  Stall, ReadData, ReadValid, MemErr, AccessCount
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData,
    output Stall, ReadData, ReadValid, MemErr, AccessCount
  );
endinterface

// File: rtl/mem_access_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, holds the pipeline
// with Stall for LAT BUSY cycles, then reports the result in a single DONE cycle.
module mem_access_responder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int LAT    = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  mem_access_responder_if.slave   bus,
  output logic [1:0]              dbg_state_o
);
  // Handshake: a request is offered while MemRead|MemWrite is high and is taken in IDLE
  // on the edge it is seen; the pipeline must hold it while Stall=1 and advances it at
  // the end of the DONE cycle (Stall=0). ReadValid/MemErr are one-cycle result pulses.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_ERR = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [5:0]        count_q, count_d;
  logic [31:0]       mem_q [DEPTH];

  logic req;
  logic illegal;
  logic fire;
  logic ram_we;

  assign req     = bus.MemRead | bus.MemWrite;
  assign illegal = (bus.MemRead & bus.MemWrite) || (bus.Address[1:0] != 2'b00) ||
                   (bus.Address[31:ADDR_W+2] != '0);
  assign fire    = (state_q == BUSY) && (cnt_q == 4'd0);
  assign ram_we  = fire && (op_q == OP_WR) && !Reset;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    idx_d    = idx_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = illegal ? OP_ERR : (bus.MemWrite ? OP_WR : OP_RD);
          idx_d   = bus.Address[ADDR_W+1:2];
          data_d  = bus.WriteData;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (op_q == OP_ERR) begin
            err_d = 1'b1;
          end else begin
            count_d = count_q + 6'd1;
            if (op_q == OP_RD) begin
              rdata_d  = mem_q[idx_q];
              rvalid_d = 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_q     <= OP_RD;
      idx_q    <= '0;
      data_q   <= 32'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 6'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // RAM contents survive reset; only the commit of an in-flight write is suppressed.
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign bus.Stall       = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign bus.ReadData    = rdata_q;
  assign bus.ReadValid   = rvalid_q;
  assign bus.MemErr      = err_q;
  assign bus.AccessCount = count_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_mem_access_responder.sv
// Directed bench for mem_access_responder: LAT=2 main instance plus a LAT=1 instance
// for the short-latency timing case.
module tb_mem_access_responder;
  logic clk;
  logic rst;
  logic [1:0] dbg0, dbg1;

  mem_access_responder_if bus0 ();
  mem_access_responder_if bus1 ();

  mem_access_responder #(.DEPTH(64), .ADDR_W(6), .LAT(2)) u_dut (
    .Clk(clk), .Reset(rst), .bus(bus0.slave), .dbg_state_o(dbg0)
  );

  mem_access_responder #(.DEPTH(64), .ADDR_W(6), .LAT(1)) u_dut1 (
    .Clk(clk), .Reset(rst), .bus(bus1.slave), .dbg_state_o(dbg1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_cnt [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic we, input logic re,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 0) begin
      bus0.MemWrite = we; bus0.MemRead = re; bus0.Address = addr; bus0.WriteData = wd;
    end else begin
      bus1.MemWrite = we; bus1.MemRead = re; bus1.Address = addr; bus1.WriteData = wd;
    end
  endtask

  // Called 1 time unit after a rising edge (start of cycle 0); returns at the start
  // of cycle lat+2 with the request still on the inputs.
  task automatic do_access(input int sel, input int lat, input logic we, input logic re,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd);
    logic is_err;
    logic [5:0] cnt_before;
    is_err = (we & re) || (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0);
    cnt_before = exp_cnt[sel];
    drive(sel, we, re, addr, wd);
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c <= lat) begin
        check($sformatf("stall_c%0d", c), {31'd0, sel ? bus1.Stall : bus0.Stall}, 32'd1);
        check($sformatf("rvalid_c%0d", c), {31'd0, sel ? bus1.ReadValid : bus0.ReadValid}, 32'd0);
        check($sformatf("cnt_c%0d", c), {26'd0, sel ? bus1.AccessCount : bus0.AccessCount},
              {26'd0, cnt_before});
      end else begin
        if (!is_err) exp_cnt[sel] = exp_cnt[sel] + 6'd1;
        check("done_stall", {31'd0, sel ? bus1.Stall : bus0.Stall}, 32'd0);
        check("done_rvalid", {31'd0, sel ? bus1.ReadValid : bus0.ReadValid},
              {31'd0, re & ~is_err});
        check("done_err", {31'd0, sel ? bus1.MemErr : bus0.MemErr}, {31'd0, is_err});
        check("done_rdata", sel ? bus1.ReadData : bus0.ReadData, exp_rd);
        check("done_cnt", {26'd0, sel ? bus1.AccessCount : bus0.AccessCount},
              {26'd0, exp_cnt[sel]});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, bus0.ReadData, 32'd0);
    check({tag, "_rvalid"}, {31'd0, bus0.ReadValid}, 32'd0);
    check({tag, "_err"}, {31'd0, bus0.MemErr}, 32'd0);
    check({tag, "_cnt"}, {26'd0, bus0.AccessCount}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg0}, 32'd0);
    check({tag, "_stall"}, {31'd0, bus0.Stall}, 32'd0);
  endtask

  initial begin
    exp_cnt[0] = 6'd0;
    exp_cnt[1] = 6'd0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write then read
    do_access(0, 2, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0);
    do_access(0, 2, 1'b0, 1'b1, 32'h10, 32'd0, 32'hDEADBEEF);
    check("cnt_after_wr_rd", {26'd0, bus0.AccessCount}, 32'd2);

    // Back-to-back with the same read held on the inputs: each must be taken exactly once
    do_access(0, 2, 1'b1, 1'b0, 32'h20, 32'h1234, 32'hDEADBEEF);
    do_access(0, 2, 1'b0, 1'b1, 32'h20, 32'd0, 32'h1234);
    do_access(0, 2, 1'b0, 1'b1, 32'h20, 32'd0, 32'h1234);
    go_idle();
    check("cnt_b2b", {26'd0, bus0.AccessCount}, 32'd5);

    // Read and write together is illegal; RAM[8] and ReadData untouched
    do_access(0, 2, 1'b1, 1'b1, 32'h20, 32'h9999, 32'h1234);
    go_idle();
    do_access(0, 2, 1'b0, 1'b1, 32'h20, 32'd0, 32'h1234);
    go_idle();

    // Misaligned and out-of-range writes must not alias onto RAM[4] / RAM[0]
    do_access(0, 2, 1'b1, 1'b0, 32'h0, 32'h0BAD0000, 32'h1234);
    do_access(0, 2, 1'b1, 1'b0, 32'h13, 32'h7777, 32'h1234);
    do_access(0, 2, 1'b1, 1'b0, 32'h100, 32'h5151, 32'h1234);
    do_access(0, 2, 1'b0, 1'b1, 32'h10, 32'd0, 32'hDEADBEEF);
    do_access(0, 2, 1'b0, 1'b1, 32'h0, 32'd0, 32'h0BAD0000);
    go_idle();
    check("cnt_after_errs", {26'd0, bus0.AccessCount}, 32'd9);

    // Reset during BUSY of a write aborts it
    do_access(0, 2, 1'b1, 1'b0, 32'h04, 32'hAA, 32'h0BAD0000);
    drive(0, 1'b1, 1'b0, 32'h04, 32'h55);
    @(posedge clk); #1;
    check("midrst_busy", {30'd0, dbg0}, 32'd1);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt[0] = 6'd0;
    exp_cnt[1] = 6'd0;
    @(posedge clk); #1;
    do_access(0, 2, 1'b0, 1'b1, 32'h04, 32'd0, 32'hAA);
    go_idle();

    // 63 more legal accesses bring the count from 1 through 63 and wrap to 0
    for (int i = 0; i < 62; i++) do_access(0, 2, 1'b0, 1'b1, 32'h04, 32'd0, 32'hAA);
    check("cnt_63", {26'd0, bus0.AccessCount}, 32'd63);
    do_access(0, 2, 1'b0, 1'b1, 32'h04, 32'd0, 32'hAA);
    go_idle();
    check("cnt_wrap", {26'd0, bus0.AccessCount}, 32'd0);

    // LAT=1 instance: result pulse in cycle 2
    do_access(1, 1, 1'b1, 1'b0, 32'h08, 32'h31, 32'd0);
    do_access(1, 1, 1'b0, 1'b1, 32'h08, 32'd0, 32'h31);
    go_idle();
    check("lat1_cnt", {26'd0, bus1.AccessCount}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
